// File: rtl/vc_regfile_drain_pkg.sv
// vc_regfile_drain shared package.
// FSM encoding and address/length width helpers.
package vc_regfile_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int addr_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so a full-file length is representable
  function automatic int len_nbits(input int n);
    return addr_nbits(n) + 1;
  endfunction

endpackage

// File: rtl/vc_regfile_drain_if.sv
// vc_regfile_drain bundle: command, register-file ports,
// and output stream, all in the domain carried by `domain`.
interface vc_regfile_drain_if
  import vc_regfile_drain_pkg::*;
#(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 32
);

  localparam int c_addr_nbits = addr_nbits(p_num_entries);
  localparam int c_len_nbits  = len_nbits(p_num_entries);

  logic                    domain;
  logic                    cmd_val;
  logic                    cmd_rdy;
  logic [c_addr_nbits-1:0] cmd_base;
  logic [c_len_nbits-1:0]  cmd_len;
  logic                    cmd_clear;
  logic [c_addr_nbits-1:0] rf_read_addr;
  logic [p_data_nbits-1:0] rf_read_data;
  logic                    rf_write_en;
  logic [c_addr_nbits-1:0] rf_write_addr;
  logic [p_data_nbits-1:0] rf_write_data;
  logic                    out_val;
  logic                    out_rdy;
  logic [p_data_nbits-1:0] out_data;
  logic                    out_last;

  modport master (
    input  domain,
    input  cmd_val,
    output cmd_rdy,
    input  cmd_base,
    input  cmd_len,
    input  cmd_clear,
    output rf_read_addr,
    input  rf_read_data,
    output rf_write_en,
    output rf_write_addr,
    output rf_write_data,
    output out_val,
    input  out_rdy,
    output out_data,
    output out_last
  );

  modport slave (
    output domain,
    output cmd_val,
    input  cmd_rdy,
    output cmd_base,
    output cmd_len,
    output cmd_clear,
    input  rf_read_addr,
    output rf_read_data,
    input  rf_write_en,
    input  rf_write_addr,
    input  rf_write_data,
    input  out_val,
    output out_rdy,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/vc_WrapCounter.sv
// Loadable address counter that wraps at p_num_entries-1,
// so non-power-of-two depths sweep correctly.
module vc_WrapCounter #(
  parameter int p_num_entries = 32,
  parameter int p_addr_nbits  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [p_addr_nbits-1:0] load_val,
  input  logic                    en,
  output logic [p_addr_nbits-1:0] count
);

  localparam logic [p_addr_nbits-1:0] c_top =
    p_addr_nbits'(p_num_entries - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (count == c_top) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vc_regfile_drain.sv
// Burst read-side master for a 1r1w register file with
// optional read-and-clear and domain-change abort.
module vc_regfile_drain
  import vc_regfile_drain_pkg::*;
#(
  parameter int p_data_nbits  = 32,
  parameter int p_num_entries = 32
) (
  input logic                clk,
  input logic                reset,
  vc_regfile_drain_if.master bus
);

  localparam int c_addr_nbits = addr_nbits(p_num_entries);
  localparam int c_len_nbits  = len_nbits(p_num_entries);
  localparam logic [c_len_nbits-1:0] c_max =
    c_len_nbits'(p_num_entries);

  state_e                  state;
  state_e                  state_n;
  logic [c_len_nbits-1:0]  rem;
  logic [c_len_nbits-1:0]  len_c;
  logic [c_addr_nbits-1:0] cur;
  logic                    dom_q;
  logic                    clr_q;
  logic                    accept;
  logic                    abort;
  logic                    last;
  logic                    fire;

  assign len_c  = (bus.cmd_len > c_max) ? c_max : bus.cmd_len;
  assign accept = (state == IDLE) && bus.cmd_val;
  assign abort  = (state == RUN) && (bus.domain != dom_q);
  assign last   = (rem == c_len_nbits'(1));
  assign fire   = bus.out_val && bus.out_rdy;

  always_comb begin
    state_n      = state;
    bus.cmd_rdy  = 1'b0;
    bus.out_val  = 1'b0;
    bus.out_last = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        bus.cmd_rdy = 1'b1;
        if (bus.cmd_val && (len_c != '0)) begin
          state_n = RUN;
        end
      end
      (state == RUN): begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          bus.out_val  = 1'b1;
          bus.out_last = last;
          if (bus.out_rdy && last) begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rem   <= '0;
      dom_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        rem   <= len_c;
        dom_q <= bus.domain;
        clr_q <= bus.cmd_clear;
      end else if (abort) begin
        rem <= '0;
      end else if (fire) begin
        rem <= rem - 1'b1;
      end
    end
  end

  vc_WrapCounter #(
    .p_num_entries (p_num_entries),
    .p_addr_nbits  (c_addr_nbits)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.cmd_base),
    .en       (fire),
    .count    (cur)
  );

  // Read is combinational, so the beat leaves before its clear lands
  assign bus.rf_read_addr  = cur;
  assign bus.out_data      = bus.rf_read_data;
  assign bus.rf_write_addr = cur;
  assign bus.rf_write_data = p_data_nbits'(0);
  assign bus.rf_write_en   = fire && clr_q && reset;

endmodule

// File: tb/tb_vc_regfile_drain.sv
// Randomized bench for vc_regfile_drain against a
// burst-level model of the register-file contents.
module tb_vc_regfile_drain;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int AW = 3;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vc_regfile_drain_if #(
    .p_data_nbits  (W),
    .p_num_entries (N)
  ) bus ();

  vc_regfile_drain #(
    .p_data_nbits  (W),
    .p_num_entries (N)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  logic [W-1:0] rf [N];
  logic [W-1:0] ref_rf [N];

  assign bus.rf_read_data = rf[bus.rf_read_addr];

  always @(posedge clk) begin
    if (bus.rf_write_en) rf[bus.rf_write_addr] <= bus.rf_write_data;
  end

  int checks = 0;
  int failures = 0;

  logic [W-1:0] got [$];
  logic [W-1:0] exp [$];
  int beats, nlast, last_beat, last_cyc, first_cyc;
  int timeout, wr_bad, hold_bad;
  logic acc_rdy, rdy_at_last, rdy_after, val_after;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic fill_inc();
    for (int i = 0; i < N; i++) begin
      rf[i] <= W'(32'h100 + i);
      ref_rf[i] = W'(32'h100 + i);
    end
    @(posedge clk); #1;
  endtask

  task automatic fill_rand();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = $urandom;
      rf[i] <= v;
      ref_rf[i] = v;
    end
    @(posedge clk); #1;
  endtask

  // Expected beats: min(len,N) entries from base, modulo N
  task automatic model(input int base, input int len, input bit clr);
    int n;
    n = (len > N) ? N : len;
    exp.delete();
    for (int i = 0; i < n; i++) exp.push_back(ref_rf[(base + i) % N]);
    if (clr) for (int i = 0; i < n; i++) ref_rf[(base + i) % N] = '0;
  endtask

  task automatic burst(input int base, input int len,
                       input bit clr, input int stall);
    logic [W-1:0] prev;
    bit stalled;
    bit done;
    got.delete();
    beats = 0; nlast = 0; last_beat = -1;
    last_cyc = -1; first_cyc = -1; timeout = 0;
    stalled = 0; prev = '0; rdy_at_last = 1'bx;
    bus.cmd_base = AW'(base);
    bus.cmd_len = LW'(len);
    bus.cmd_clear = clr;
    bus.cmd_val = 1'b1;
    bus.out_rdy = 1'b0;
    #2;
    acc_rdy = bus.cmd_rdy;
    @(posedge clk); #1;
    bus.cmd_val = 1'b0;
    for (int cyc = 1; ; cyc++) begin
      bus.out_rdy = ($urandom_range(99) >= stall);
      #2;
      if (!bus.out_val) break;
      if (stalled && bus.out_data !== prev) hold_bad++;
      if (bus.rf_write_en !== (bus.out_rdy && clr)) wr_bad++;
      if (bus.rf_write_en &&
          bus.rf_write_addr !== bus.rf_read_addr) wr_bad++;
      done = 0;
      if (bus.out_rdy) begin
        got.push_back(bus.out_data);
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.out_last) begin
          nlast++;
          last_beat = beats;
          last_cyc = cyc;
          rdy_at_last = bus.cmd_rdy;
          done = 1;
        end
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        prev = bus.out_data;
      end
      @(posedge clk); #1;
      if (done) break;
      if (cyc > 300) begin
        timeout = 1;
        break;
      end
    end
    bus.out_rdy = 1'b0;
    #2;
    rdy_after = bus.cmd_rdy;
    val_after = bus.out_val;
  endtask

  task automatic test_reset();
    bus.domain = 0; bus.cmd_val = 0; bus.cmd_base = '0;
    bus.cmd_len = '0; bus.cmd_clear = 0; bus.out_rdy = 0;
    for (int i = 0; i < N; i++) begin
      rf[i] <= '0;
      ref_rf[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    checks++;
    if (bus.cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_rdy got=%b exp=1", bus.cmd_rdy);
    end
    checks++;
    if ({bus.out_val, bus.out_last, bus.rf_write_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl got=%b%b%b exp=000",
               bus.out_val, bus.out_last, bus.rf_write_en);
    end
    checks++;
    if (bus.rf_read_addr !== '0 || bus.rf_write_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%0d/%0d exp=0/0",
               bus.rf_read_addr, bus.rf_write_addr);
    end
    checks++;
    if (bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", bus.out_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_plain();
    fill_inc();
    model(2, 3, 0);
    burst(2, 3, 0, 0);
    checks++;
    if (beats !== 3) begin
      failures++;
      $display("FAIL plain_beats got=%0d exp=3", beats);
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(32'h102 + i)) begin
        failures++;
        $display("FAIL plain_data[%0d] got=%h exp=%h",
                 i, got[i], 32'h102 + i);
      end
    end
    checks++;
    if (first_cyc !== 1 || last_cyc !== 3 || nlast !== 1) begin
      failures++;
      $display("FAIL plain_timing got=%0d/%0d/%0d exp=1/3/1",
               first_cyc, last_cyc, nlast);
    end
    checks++;
    if (rdy_at_last !== 1'b0 || rdy_after !== 1'b1) begin
      failures++;
      $display("FAIL plain_cmd_rdy got=%b/%b exp=0/1",
               rdy_at_last, rdy_after);
    end
    checks++;
    if (wr_bad !== 0) begin
      failures++;
      $display("FAIL plain_writes got=%0d exp=0", wr_bad);
    end
  endtask

  task automatic test_wrap_clear();
    model(6, 4, 1);
    burst(6, 4, 1, 0);
    checks++;
    if (beats !== 4 || nlast !== 1) begin
      failures++;
      $display("FAIL wrap_beats got=%0d/%0d exp=4/1", beats, nlast);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(32'h100 + ((6 + i) % N))) begin
        failures++;
        $display("FAIL wrap_data[%0d] got=%h exp=%h",
                 i, got[i], 32'h100 + ((6 + i) % N));
      end
    end
    model(6, 4, 0);
    burst(6, 4, 0, 0);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== '0) begin
        failures++;
        $display("FAIL wrap_cleared[%0d] got=%h exp=0", i, got[i]);
      end
    end
    checks++;
    if (rf[2] !== W'(32'h102) || wr_bad !== 0) begin
      failures++;
      $display("FAIL wrap_untouched got=%h/%0d exp=102/0",
               rf[2], wr_bad);
    end
  endtask

  task automatic test_backpressure();
    fill_inc();
    bus.cmd_base = '0; bus.cmd_len = LW'(2);
    bus.cmd_clear = 1; bus.cmd_val = 1; bus.out_rdy = 0;
    #2;
    @(posedge clk); #1;
    bus.cmd_val = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (bus.out_val !== 1'b1 || bus.out_data !== W'(32'h100) ||
          bus.rf_write_en !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/100/0",
                 c, bus.out_val, bus.out_data, bus.rf_write_en);
      end
      @(posedge clk); #1;
    end
    bus.out_rdy = 1;
    #2;
    checks++;
    if (bus.rf_write_en !== 1'b1 || bus.rf_write_addr !== '0 ||
        bus.out_data !== W'(32'h100) || bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL bp_fire got=%b/%0d/%h/%b exp=1/0/100/0",
               bus.rf_write_en, bus.rf_write_addr,
               bus.out_data, bus.out_last);
    end
    @(posedge clk); #1;
    #2;
    checks++;
    if (bus.out_data !== W'(32'h101) || bus.out_last !== 1'b1) begin
      failures++;
      $display("FAIL bp_last got=%h/%b exp=101/1",
               bus.out_data, bus.out_last);
    end
    @(posedge clk); #1;
    bus.out_rdy = 0;
    #2;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || rf[0] !== '0 || rf[1] !== '0) begin
      failures++;
      $display("FAIL bp_after got=%b/%h/%h exp=1/0/0",
               bus.cmd_rdy, rf[0], rf[1]);
    end
    ref_rf[0] = '0;
    ref_rf[1] = '0;
  endtask

  task automatic test_len_edges();
    model(3, 0, 1);
    burst(3, 0, 1, 0);
    checks++;
    if (beats !== 0 || val_after !== 1'b0 || rdy_after !== 1'b1) begin
      failures++;
      $display("FAIL len0 got=%0d/%b/%b exp=0/0/1",
               beats, val_after, rdy_after);
    end
    fill_inc();
    model(5, 15, 0);
    burst(5, 15, 0, 0);
    checks++;
    if (beats !== N || last_cyc !== N || nlast !== 1) begin
      failures++;
      $display("FAIL len_clamp got=%0d/%0d/%0d exp=%0d/%0d/1",
               beats, last_cyc, nlast, N, N);
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++;
        $display("FAIL len_clamp_data[%0d] got=%h exp=%h",
                 i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    fill_inc();
    bus.cmd_base = AW'(1); bus.cmd_len = LW'(5);
    bus.cmd_clear = 1; bus.cmd_val = 1; bus.out_rdy = 1;
    #2;
    @(posedge clk); #1;
    bus.cmd_val = 0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (bus.out_val !== 1'b1 || bus.out_data !== W'(32'h101 + c)) begin
        failures++;
        $display("FAIL abort_beat[%0d] got=%b/%h exp=1/%h",
                 c, bus.out_val, bus.out_data, 32'h101 + c);
      end
      @(posedge clk); #1;
    end
    bus.domain = ~bus.domain;
    #2;
    checks++;
    if (bus.out_val !== 1'b0 || bus.rf_write_en !== 1'b0 ||
        bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL abort_cycle got=%b/%b/%b exp=0/0/0",
               bus.out_val, bus.rf_write_en, bus.out_last);
    end
    @(posedge clk); #1;
    #2;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.out_val !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b/%b exp=1/0",
               bus.cmd_rdy, bus.out_val);
    end
    checks++;
    if (rf[1] !== '0 || rf[2] !== '0 || rf[3] !== W'(32'h103)) begin
      failures++;
      $display("FAIL abort_rf got=%h/%h/%h exp=0/0/103",
               rf[1], rf[2], rf[3]);
    end
    bus.out_rdy = 0;
    ref_rf[1] = '0;
    ref_rf[2] = '0;
  endtask

  task automatic test_reset_mid();
    fill_inc();
    bus.cmd_base = '0; bus.cmd_len = LW'(6);
    bus.cmd_clear = 1; bus.cmd_val = 1; bus.out_rdy = 1;
    #2;
    @(posedge clk); #1;
    bus.cmd_val = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (bus.rf_write_en !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_we[%0d] got=%b exp=0",
                 c, bus.rf_write_en);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.out_rdy = 0;
    #2;
    checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.out_val !== 1'b0 ||
        bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle got=%b/%b/%b exp=1/0/0",
               bus.cmd_rdy, bus.out_val, bus.out_last);
    end
    checks++;
    if (rf[0] !== '0 || rf[1] !== '0 || rf[2] !== W'(32'h102)) begin
      failures++;
      $display("FAIL rst_mid_rf got=%h/%h/%h exp=0/0/102",
               rf[0], rf[1], rf[2]);
    end
    ref_rf[0] = '0;
    ref_rf[1] = '0;
  endtask

  task automatic test_random();
    int base, len, stall, bad;
    bit clr;
    wr_bad = 0;
    hold_bad = 0;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(3) == 0) fill_rand();
      base = $urandom_range(N - 1);
      len = $urandom_range((1 << LW) - 1);
      clr = 1'($urandom_range(1));
      stall = $urandom_range(60);
      model(base, len, clr);
      burst(base, len, clr, stall);
      checks++;
      if (acc_rdy !== 1'b1 || timeout !== 0 ||
          beats !== exp.size()) begin
        failures++;
        $display("FAIL rnd_beats[%0d] got=%b/%0d/%0d exp=1/0/%0d",
                 it, acc_rdy, timeout, beats, exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          failures++;
          $display("FAIL rnd_data[%0d.%0d] got=%h exp=%h",
                   it, i, got[i], exp[i]);
        end
      end
      checks++;
      if (nlast !== (exp.size() > 0 ? 1 : 0) ||
          (exp.size() > 0 && last_beat !== exp.size() - 1) ||
          rdy_after !== 1'b1) begin
        failures++;
        $display("FAIL rnd_last[%0d] got=%0d/%0d/%b exp=%0d/%0d/1",
                 it, nlast, last_beat, rdy_after,
                 exp.size() > 0, exp.size() - 1);
      end
      bad = 0;
      for (int i = 0; i < N; i++) if (rf[i] !== ref_rf[i]) bad++;
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rnd_rf[%0d] got=%0d_diffs exp=0", it, bad);
      end
    end
    checks++;
    if (wr_bad !== 0 || hold_bad !== 0) begin
      failures++;
      $display("FAIL rnd_protocol got=%0d/%0d exp=0/0",
               wr_bad, hold_bad);
    end
  endtask

  initial begin
    wr_bad = 0;
    hold_bad = 0;
    test_reset();
    test_plain();
    test_wrap_clear();
    test_backpressure();
    test_len_edges();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
